// File: rtl/dmem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder_if                                                    |
// | Request/response bundle between EX control and the data memory.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dmem_responder_if;
  logic       MemRead;
  logic       MemWrite;
  logic       MDRload;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] MDR;
  logic       ready;
  logic       stall;
  logic       conflict;

  modport master (
    output MemRead, MemWrite, MDRload, addr, wdata,
    input  MDR, ready, stall, conflict
  );

  modport slave (
    input  MemRead, MemWrite, MDRload, addr, wdata,
    output MDR, ready, stall, conflict
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder                                                       |
// | 256x8 data memory with MDR capture, ready/conflict pulses and an     |
// | optional one-cycle wait state selected by DMEM_WAIT_STATE_EN.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_responder (
  input  wire logic       clock,
  input  wire logic       reset,
  dmem_responder_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [7:0] r_mem [0:255];
  logic [7:0] r_mdr;
  logic       r_ready;
  logic       r_conflict;

  logic       w_accept;
  logic       w_req;
  logic       w_do_access;
  logic       w_is_write;
  logic       w_load;
  logic       w_conf;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;

  // DONE samples requests exactly like IDLE; nothing is sampled in WAIT.
  assign w_accept = (r_state == IDLE) || (r_state == DONE);
  assign w_req    = bus.MemRead | bus.MemWrite;

`ifdef DMEM_WAIT_STATE_EN
  logic       r_op_write;
  logic       r_op_load;
  logic       r_op_conf;
  logic [7:0] r_op_addr;
  logic [7:0] r_op_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op_write <= 1'b0;
      r_op_load  <= 1'b0;
      r_op_conf  <= 1'b0;
      r_op_addr  <= 8'h00;
      r_op_wdata <= 8'h00;
    end else if (w_accept && w_req) begin
      r_op_write <= bus.MemWrite;
      r_op_load  <= bus.MemRead & ~bus.MemWrite & bus.MDRload;
      r_op_conf  <= bus.MemRead & bus.MemWrite;
      r_op_addr  <= bus.addr;
      r_op_wdata <= bus.wdata;
    end
  end

  assign w_do_access = (r_state == WAIT);
  assign w_is_write  = r_op_write;
  assign w_load      = r_op_load;
  assign w_conf      = r_op_conf;
  assign w_addr      = r_op_addr;
  assign w_wdata     = r_op_wdata;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_req ? WAIT : IDLE;
      WAIT:    w_state_next = DONE;
      DONE:    w_state_next = w_req ? WAIT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end
`else
  // Access happens at the sampling edge; a write wins over a simultaneous read.
  assign w_do_access = w_accept & w_req;
  assign w_is_write  = bus.MemWrite;
  assign w_load      = bus.MemRead & ~bus.MemWrite & bus.MDRload;
  assign w_conf      = bus.MemRead & bus.MemWrite;
  assign w_addr      = bus.addr;
  assign w_wdata     = bus.wdata;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_req ? DONE : IDLE;
      DONE:    w_state_next = w_req ? DONE : IDLE;
      WAIT:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mdr      <= 8'h00;
      r_ready    <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ready    <= w_do_access;
      r_conflict <= w_do_access & w_conf;
      if (w_do_access && w_load) begin
        r_mdr <= r_mem[w_addr];
      end
    end
  end

  // Array has no reset so its contents survive a reset.
  always_ff @(posedge clock) begin
    if (w_do_access && w_is_write) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  assign bus.MDR      = r_mdr;
  assign bus.ready    = r_ready;
  assign bus.stall    = (r_state == WAIT);
  assign bus.conflict = r_conflict;
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_responder                                                    |
// | Directed vector table plus reset and back-to-back sequences.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dmem_responder;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  dmem_responder_if bus ();

  dmem_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rd;
    logic       wr;
    logic       load;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] mdr;
    logic       rdy;
    logic       conf;
  } vec_t;

  vec_t vecs [12];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic load,
                       input logic [7:0] a, input logic [7:0] d);
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.MDRload  = load;
    bus.addr     = a;
    bus.wdata    = d;
  endtask

  // Issue one request and return at the negedge just after the access edge.
  task automatic access(input logic rd, input logic wr, input logic load,
                        input logic [7:0] a, input logic [7:0] d);
    drive(rd, wr, load, a, d);
    tick;
`ifdef DMEM_WAIT_STATE_EN
    check("stall_in_wait", {7'd0, bus.stall}, {7'd0, rd | wr});
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick;
`endif
  endtask

  initial begin
    //          rd    wr    load  addr   wdata  MDR    ready conflict
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h10, 8'hA5, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 8'hA5, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'h20, 8'h55, 8'hA5, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 8'h55, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h77, 8'h55, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h77, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h12, 8'h77, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h77, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 8'h77, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h3C, 8'h77, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h3C, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 8'hA5, 1'b1, 1'b0};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick;
    tick;
    check("rst_mdr",      bus.MDR,                8'h00);
    check("rst_ready",    {7'd0, bus.ready},      8'h00);
    check("rst_stall",    {7'd0, bus.stall},      8'h00);
    check("rst_conflict", {7'd0, bus.conflict},   8'h00);
    reset = 1'b0;

    // First request goes out right at release so the first edge samples it.
    for (int i = 0; i < 12; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].load, vecs[i].a, vecs[i].d);
      check($sformatf("v%0d_mdr", i),      bus.MDR,              vecs[i].mdr);
      check($sformatf("v%0d_ready", i),    {7'd0, bus.ready},    {7'd0, vecs[i].rdy});
      check($sformatf("v%0d_conflict", i), {7'd0, bus.conflict}, {7'd0, vecs[i].conf});
      check($sformatf("v%0d_stall", i),    {7'd0, bus.stall},    8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      tick;
      check($sformatf("v%0d_ready_end", i),    {7'd0, bus.ready},    8'h00);
      check($sformatf("v%0d_conflict_end", i), {7'd0, bus.conflict}, 8'h00);
    end

    // Asynchronous reset while ready is high; array must survive.
    access(1'b0, 1'b1, 1'b0, 8'h30, 8'hC3);
    check("pre_rst_ready", {7'd0, bus.ready}, 8'h01);
    #2 reset = 1'b1;
    #1;
    check("async_rst_mdr",      bus.MDR,              8'h00);
    check("async_rst_ready",    {7'd0, bus.ready},    8'h00);
    check("async_rst_stall",    {7'd0, bus.stall},    8'h00);
    check("async_rst_conflict", {7'd0, bus.conflict}, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick;
    reset = 1'b0;
    access(1'b1, 1'b0, 1'b1, 8'h30, 8'h00);
    check("post_rst_read", bus.MDR,           8'hC3);
    check("post_rst_ready", {7'd0, bus.ready}, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick;

`ifdef DMEM_WAIT_STATE_EN
    // Reset during WAIT must drop the pending write of 8'h99.
    access(1'b0, 1'b1, 1'b0, 8'h40, 8'h11);
    drive(1'b0, 1'b1, 1'b0, 8'h40, 8'h99);
    tick;
    check("wait_stall", {7'd0, bus.stall}, 8'h01);
    #2 reset = 1'b1;
    #1;
    check("wait_rst_stall", {7'd0, bus.stall}, 8'h00);
    check("wait_rst_ready", {7'd0, bus.ready}, 8'h00);
    check("wait_rst_mdr",   bus.MDR,           8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick;
    reset = 1'b0;
    access(1'b1, 1'b0, 1'b1, 8'h40, 8'h00);
    check("wait_rst_read", bus.MDR, 8'h11);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick;
`endif

    // Back-to-back write/read over the whole address range.
    for (int a = 0; a < 256; a++) begin
      access(1'b0, 1'b1, 1'b0, 8'(a), 8'(a) ^ 8'h5A);
      check($sformatf("sweep_w%0d_ready", a), {7'd0, bus.ready}, 8'h01);
      access(1'b1, 1'b0, 1'b1, 8'(a), 8'h00);
      check($sformatf("sweep_r%0d_ready", a), {7'd0, bus.ready}, 8'h01);
      check($sformatf("sweep_r%0d_mdr", a),   bus.MDR,           8'(a) ^ 8'h5A);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick;
    check("sweep_end_ready", {7'd0, bus.ready}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL use clock `clock` (rising-edge active) and reset `reset` (asynchronous, active-high).
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clock  input  1  system clock
- reset  input  1  asynchronous active-high reset
- MemRead  input  1  read request from EX control
- MemWrite  input  1  write request from EX control
- MDRload  input  1  capture read data into MDR
- addr  input  8  byte address, from the ALU / register operand
- wdata  input  8  store data
- MDR  output  8  memory data register, feeding writeback
- ready  output  1  one-cycle pulse on access completion
- stall  output  1  pipeline hold while an access is pending
- conflict  output  1  one-cycle pulse on a simultaneous read and write

Function
REQ-003 The block SHALL contain a 256x8 data array, indexed by `addr` with no wrap logic (full 8-bit range).
REQ-004 The FSM states SHALL be IDLE, WAIT and DONE. DONE SHALL accept a new request exactly as IDLE does.
REQ-005 A request SHALL be sampled only in IDLE or DONE. Requests are ignored while `stall` is 1, and the requester holds them.
REQ-006 Write: `mem[addr]` SHALL take the value of `wdata`. `MDR` SHALL be unchanged.
REQ-007 Read with `MDRload`=1: `MDR` SHALL take the value of `mem[addr]`.
REQ-008 Read with `MDRload`=0: the access SHALL complete (`ready` pulses) and `MDR` SHALL hold its value.
REQ-009 `MDRload`=1 without `MemRead`: no access, no `ready`, and `MDR` held.
REQ-010 `MemRead` and `MemWrite` both 1 in a sampling cycle: the access SHALL be treated as a write only, and `conflict` SHALL be 1 for the following cycle.
REQ-011 `ready` SHALL be 1 for exactly the one cycle after the edge at which the array or `MDR` is updated, and 0 otherwise.
REQ-012 Back-to-back requests SHALL be accepted on consecutive sampling edges without a bubble beyond that set by the configuration.
REQ-013 A read of an address written on the immediately preceding access SHALL return the new data (no stale read).

Reset
REQ-014 On `reset`=1, asynchronously: state SHALL be IDLE, and `MDR`, `ready`, `stall` and `conflict` SHALL all be 0.
REQ-015 Array contents SHALL NOT be affected by reset.
REQ-016 Reset during WAIT SHALL discard the pending access: no array write and no `MDR` update.
REQ-017 After `reset` is released, the first rising edge SHALL be able to sample a request.

Configuration
REQ-018 Macro `DMEM_WAIT_STATE_EN` SHALL select the access latency.
REQ-019 Macro undefined:
- the access is performed at the sampling edge
- `ready` pulses in the next cycle
- `stall` is constant 0
- WAIT is never entered
REQ-020 Macro defined:
- at the sampling edge, `addr`, `wdata`, the operation and `MDRload` SHALL be registered, and the FSM goes to WAIT
- in WAIT, `stall` SHALL be 1 (exactly one cycle)
- at the WAIT edge, the access is performed from the registered values and the FSM goes to DONE
- in DONE, `ready` SHALL be 1 and `stall` 0
- the `conflict` pulse SHALL coincide with `ready`

Verification
REQ-021 Macro off: write `addr`=8'h10, `wdata`=8'hA5, then read 8'h10 with `MDRload`=1 -> `MDR`=8'hA5 one cycle after the read edge, `ready` pulse for 1 cycle after each access, `stall` never 1.
REQ-022 Macro on: single write of 8'h3C to 8'hFF -> `stall`=1 for exactly 1 cycle, then `ready`=1 for 1 cycle; a read of 8'hFF then returns 8'h3C.
REQ-023 `MemRead`=`MemWrite`=1, `addr`=8'h20, `wdata`=8'h55 -> `conflict` pulses for 1 cycle, `mem[8'h20]`=8'h55, `MDR` unchanged.
REQ-024 Read 8'h00 with `MDRload`=0 after `MDR`=8'h77 -> `ready` pulses, `MDR` stays 8'h77.
REQ-025 Macro on: write 8'h99 to 8'h40, assert `reset` during WAIT, release, then read 8'h40 -> previous contents returned (not 8'h99), and all outputs 0 during reset.
REQ-026 Macro off: alternating write/read every cycle over addresses 8'h00..8'hFF -> every read returns the last value written to that address, and `ready` stays 1 throughout.
